// File: rtl/tpu_pkg.sv
// Shared constants and FSM encoding for the systolic operand feeder.
package tpu_pkg;
    localparam int DATA_WIDTH   = 8;
    localparam int N            = 4;
    localparam int FEED_CYCLES  = 2 * N - 1;
    localparam int DRAIN_CYCLES = N - 1;
    // Step counter spans FEED + DRAIN, i.e. 0..9.
    localparam int STEP_W       = 4;
    localparam int IDX_W        = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } feeder_state_t;
endpackage

// File: rtl/feeder_skew_sel.sv
// One edge lane of the feeder: picks element k = t - lane of the lane's
// four tile elements, or zero when k falls outside 0..N-1.
module feeder_skew_sel
    import tpu_pkg::*;
(
    input  logic [STEP_W-1:0]     t,
    input  logic [IDX_W-1:0]      lane,
    input  logic [DATA_WIDTH-1:0] elems [N],
    output logic [DATA_WIDTH-1:0] sel
);
    // One spare bit so a negative k shows up as a set MSB instead of wrapping.
    logic [STEP_W:0] k;

    // Skewed element select with zero padding outside the tile.
    always_comb begin
        k   = {1'b0, t} - {{(STEP_W + 1 - IDX_W){1'b0}}, lane};
        sel = '0;
        if (k[STEP_W:IDX_W] == '0) begin
            sel = elems[k[IDX_W-1:0]];
        end
    end
endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the 4x4 systolic MAC array: stores A/B tiles, then
// streams them with diagonal skew and drives array clear/write/done.
// Optional feature macro: FEEDER_ACCUM_EN adds the `accumulate` input,
// which skips the CLEAR state so results sum across passes.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | waiting; tile loads accepted, start sampled
// ST_CLEAR | one-cycle accumulator clear to the array
// ST_FEED  | t = 0..6, skewed tile data on the edges
// ST_DRAIN | t = 7..9, edges zero while the wavefront finishes
// ST_DONE  | one-cycle done pulse, results final
module systolic_feeder
    import tpu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic                    load_sel,
    input  logic [1:0]              load_row,
    input  logic [N*DATA_WIDTH-1:0] load_data,
    input  logic                    start,
`ifdef FEEDER_ACCUM_EN
    input  logic                    accumulate,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    arr_clr,
    output logic                    arr_we,
    output logic [N*DATA_WIDTH-1:0] a_edge,
    output logic [N*DATA_WIDTH-1:0] b_edge
);
    feeder_state_t         state, state_next;
    logic [STEP_W-1:0]     t, t_next;
    logic [DATA_WIDTH-1:0] a_tile [N][N];
    logic [DATA_WIDTH-1:0] b_tile [N][N];
    logic [DATA_WIDTH-1:0] b_col  [N][N];
    logic [DATA_WIDTH-1:0] a_sel  [N];
    logic [DATA_WIDTH-1:0] b_sel  [N];
    logic                  skip_clear;

`ifdef FEEDER_ACCUM_EN
    assign skip_clear = accumulate;
`else
    assign skip_clear = 1'b0;
`endif

    // State register and step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            t     <= '0;
        end else begin
            state <= state_next;
            t     <= t_next;
        end
    end

    // Next-state and step-counter logic; t restarts at 0 on entry to FEED.
    always_comb begin
        state_next = state;
        t_next     = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = skip_clear ? ST_FEED : ST_CLEAR;
                end
            end
            ST_CLEAR: state_next = ST_FEED;
            ST_FEED: begin
                t_next = t + STEP_W'(1);
                if (t == STEP_W'(FEED_CYCLES - 1)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (t == STEP_W'(FEED_CYCLES + DRAIN_CYCLES - 1)) begin
                    state_next = ST_DONE;
                end else begin
                    t_next = t + STEP_W'(1);
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Tile storage; rows are written only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_tile[i][j] <= '0;
                    b_tile[i][j] <= '0;
                end
            end
        end else if (load_valid && load_ready) begin
            for (int j = 0; j < N; j++) begin
                if (load_sel) begin
                    b_tile[load_row][j] <= load_data[j*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    a_tile[load_row][j] <= load_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Lanes look ahead at t_next so the registered edges line up with arr_we.
    for (genvar g = 0; g < N; g++) begin : g_lane
        for (genvar k = 0; k < N; k++) begin : g_col
            assign b_col[g][k] = b_tile[k][g];
        end

        feeder_skew_sel u_a_sel (
            .t     (t_next),
            .lane  (IDX_W'(g)),
            .elems (a_tile[g]),
            .sel   (a_sel[g])
        );

        feeder_skew_sel u_b_sel (
            .t     (t_next),
            .lane  (IDX_W'(g)),
            .elems (b_col[g]),
            .sel   (b_sel[g])
        );
    end

    // Registered outputs, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            arr_clr    <= 1'b0;
            arr_we     <= 1'b0;
            a_edge     <= '0;
            b_edge     <= '0;
        end else begin
            load_ready <= (state_next == ST_IDLE);
            busy       <= (state_next != ST_IDLE);
            done       <= (state_next == ST_DONE);
            arr_clr    <= (state_next == ST_CLEAR);
            arr_we     <= (state_next == ST_FEED) || (state_next == ST_DRAIN);
            for (int i = 0; i < N; i++) begin
                a_edge[i*DATA_WIDTH +: DATA_WIDTH] <= (state_next == ST_FEED) ? a_sel[i] : '0;
                b_edge[i*DATA_WIDTH +: DATA_WIDTH] <= (state_next == ST_FEED) ? b_sel[i] : '0;
            end
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder. Expected edges come from the
// skew rule applied to the bench's own tile copies; a behavioural array
// fed by the DUT outputs must reproduce the plain matrix product A*B.
// Accumulation passes run only when FEEDER_ACCUM_EN is defined.
`timescale 1ns/1ps
module tb_systolic_feeder;
    import tpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic        load_sel;
    logic [1:0]  load_row;
    logic [31:0] load_data;
    logic        start;
    logic        accumulate;
    logic        busy;
    logic        done;
    logic        arr_clr;
    logic        arr_we;
    logic [31:0] a_edge;
    logic [31:0] b_edge;

    int    n_checks = 0;
    int    n_errors = 0;
    int    a_m [4][4];
    int    b_m [4][4];
    longint c_arr [4][4];
    longint c_exp [4][4];
    int    a_hist [4][10];
    int    b_hist [4][10];

    systolic_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_sel   (load_sel),
        .load_row   (load_row),
        .load_data  (load_data),
        .start      (start),
`ifdef FEEDER_ACCUM_EN
        .accumulate (accumulate),
`endif
        .busy       (busy),
        .done       (done),
        .arr_clr    (arr_clr),
        .arr_we     (arr_we),
        .a_edge     (a_edge),
        .b_edge     (b_edge)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int mode, input int r, input int c);
        case (mode)
            0:       return 8'd0;
            1:       return (r == c) ? 8'd1 : 8'd0;
            2:       return 8'(r * 4 + c + 1);
            3:       return 8'd5;
            5:       return 8'd1;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic load_tile(input bit sel, input int mode);
        logic [31:0] d;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                d[j*8 +: 8] = pat(mode, r, j);
                if (sel) b_m[r][j] = int'(d[j*8 +: 8]);
                else     a_m[r][j] = int'(d[j*8 +: 8]);
            end
            load_valid = 1'b1;
            load_sel   = sel;
            load_row   = 2'(r);
            load_data  = d;
            @(negedge clk);
            load_valid = 1'b0;
        end
    endtask

    task automatic run_pass(input bit accum, input bit with_load, input logic [31:0] ld,
                            input bit disturb, input string name);
        int lat, fs, nwe, t;
        longint prod;
        logic [31:0] ea, eb;
        lat = accum ? 11 : 12;
        fs  = accum ? 1 : 2;
        nwe = 0;
        for (int i = 0; i < 4; i++)
            for (int s = 0; s < 10; s++) begin
                a_hist[i][s] = 0;
                b_hist[i][s] = 0;
            end
        start      = 1'b1;
        accumulate = accum;
        if (with_load) begin
            load_valid = 1'b1;
            load_sel   = 1'b0;
            load_row   = 2'd0;
            load_data  = ld;
            for (int j = 0; j < 4; j++) a_m[0][j] = int'(ld[j*8 +: 8]);
        end
        @(negedge clk);
        start      = 1'b0;
        load_valid = 1'b0;
        accumulate = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            t  = c - fs;
            ea = '0;
            eb = '0;
            if (t >= 0 && t < FEED_CYCLES) begin
                for (int i = 0; i < 4; i++) begin
                    if (t - i >= 0 && t - i < 4) begin
                        ea[i*8 +: 8] = 8'(a_m[i][t - i]);
                        eb[i*8 +: 8] = 8'(b_m[t - i][i]);
                    end
                end
            end
            check($sformatf("%s arr_clr c%0d", name, c), 64'(arr_clr), 64'(!accum && c == 1));
            check($sformatf("%s arr_we c%0d", name, c), 64'(arr_we), 64'(t >= 0 && t <= 9));
            check($sformatf("%s done c%0d", name, c), 64'(done), 64'(c == lat));
            check($sformatf("%s busy c%0d", name, c), 64'(busy), 64'(c <= lat));
            check($sformatf("%s load_ready c%0d", name, c), 64'(load_ready), 64'(c == lat + 1));
            check($sformatf("%s a_edge c%0d", name, c), 64'(a_edge), 64'(ea));
            check($sformatf("%s b_edge c%0d", name, c), 64'(b_edge), 64'(eb));
            // Array model reacts to what the DUT actually drove.
            if (arr_clr)
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) c_arr[i][j] = 0;
            if (arr_we && nwe < 10) begin
                for (int i = 0; i < 4; i++) begin
                    a_hist[i][nwe] = int'(a_edge[i*8 +: 8]);
                    b_hist[i][nwe] = int'(b_edge[i*8 +: 8]);
                end
                nwe++;
            end
            if (disturb && c == 4) begin
                start      = 1'b1;
                load_valid = 1'b1;
                load_sel   = 1'($urandom_range(0, 1));
                load_row   = 2'($urandom_range(0, 3));
                load_data  = $urandom() | 32'h0101_0101;
            end else begin
                start      = 1'b0;
                load_valid = 1'b0;
            end
            @(negedge clk);
        end
        // PE(i,j) sees row i delayed by j and column j delayed by i.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int s = 0; s < nwe; s++)
                    if (s - j >= 0 && s - i >= 0)
                        c_arr[i][j] += longint'(a_hist[i][s - j]) * longint'(b_hist[j][s - i]);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                prod = 0;
                for (int k = 0; k < 4; k++) prod += longint'(a_m[i][k]) * longint'(b_m[k][j]);
                c_exp[i][j] = accum ? c_exp[i][j] + prod : prod;
                check($sformatf("%s c%0d%0d", name, i, j), 64'(c_arr[i][j]), 64'(c_exp[i][j]));
            end
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_sel   = 1'b0;
        load_row   = 2'd0;
        load_data  = '0;
        start      = 1'b0;
        accumulate = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_m[i][j] = 0; b_m[i][j] = 0; c_arr[i][j] = 0; c_exp[i][j] = 0;
            end
        repeat (2) @(negedge clk);
        check("reset load_ready", 64'(load_ready), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset arr_clr", 64'(arr_clr), 64'd0);
        check("reset arr_we", 64'(arr_we), 64'd0);
        check("reset a_edge", 64'(a_edge), 64'd0);
        check("reset b_edge", 64'(b_edge), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        load_tile(1'b0, 1);
        load_tile(1'b1, 2);
        run_pass(1'b0, 1'b0, '0, 1'b0, "ident");

        load_tile(1'b0, 3);
        load_tile(1'b1, 4);
        run_pass(1'b0, 1'b0, '0, 1'b0, "fives");

        run_pass(1'b0, 1'b1, 32'h0403_0201, 1'b0, "ldstart");

        load_tile(1'b0, 4);
        load_tile(1'b1, 4);
        run_pass(1'b0, 1'b0, '0, 1'b1, "busy");

        for (int p = 0; p < 3; p++) begin
            load_tile(1'b0, 4);
            load_tile(1'b1, 4);
            run_pass(1'b0, 1'b0, '0, 1'b0, $sformatf("rand%0d", p));
        end

        load_tile(1'b0, 4);
        load_tile(1'b1, 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst feed arr_we", 64'(arr_we), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst arr_we", 64'(arr_we), 64'd0);
        check("midrst a_edge", 64'(a_edge), 64'd0);
        check("midrst b_edge", 64'(b_edge), 64'd0);
        check("midrst load_ready", 64'(load_ready), 64'd1);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_m[i][j] = 0;
                b_m[i][j] = 0;
            end
        run_pass(1'b0, 1'b0, '0, 1'b0, "zero");

`ifdef FEEDER_ACCUM_EN
        load_tile(1'b0, 5);
        load_tile(1'b1, 5);
        run_pass(1'b0, 1'b0, '0, 1'b0, "acc0");
        run_pass(1'b1, 1'b0, '0, 1'b0, "acc1");
        check("acc1 c33 value", 64'(c_arr[3][3]), 64'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
